// File: rtl/axi_llc_pkg.sv
// Shared LLC types: the cache configuration record and the partition index FSM states.
// The partition table entry type is declared in the index unit, where its width is known.
package axi_llc_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned BlockSize;
    int unsigned TagLength;
    int unsigned IndexLength;
    int unsigned BlockOffsetLength;
    int unsigned ByteOffsetLength;
  } llc_cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } part_idx_state_e;

  // A single partition still needs a one-bit id port.
  function automatic int unsigned part_id_width(input int unsigned num_parts);
    return (num_parts > 1) ? $clog2(num_parts) : 1;
  endfunction

endpackage

// File: rtl/axi_llc_iter_mod.sv
// Restoring-remainder unit: one quotient bit per cycle, Width cycles per operation.
// done_o flags the cycle whose clock edge retires the last step; rem_o then holds the final remainder.
module axi_llc_iter_mod #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width:0]   divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] rem_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  logic             busy_q, busy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] dvd_q, dvd_d;
  logic [Width:0]   dvs_q, dvs_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width:0]   trial;
  logic [Width-1:0] rem_step;

  // The partial remainder stays below the divisor (<= 2^Width), so it fits Width bits.
  always_comb begin
    trial    = {rem_q, dvd_q[cnt_q]};
    rem_step = Width'((trial >= dvs_q) ? (trial - dvs_q) : trial);
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(Width - 1);
      dvd_d  = dividend_i;
      dvs_d  = divisor_i;
      rem_d  = '0;
    end else if (busy_q) begin
      rem_d = rem_step;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == '0);
  assign rem_o  = rem_step;

endmodule

// File: rtl/axi_llc_partition_index_unit.sv
// Partition-aware set index: start + (line index % size) from a programmable partition table,
// falling back to a shared region; power-of-two sizes bypass the iterative modulo.
module axi_llc_partition_index_unit
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t     Cfg           = llc_cfg_t'{default: '0},
  parameter int unsigned  NumPartitions = 4,
  parameter type          addr_t        = logic,
  localparam int unsigned IndexLength   = (Cfg.IndexLength > 0) ? Cfg.IndexLength : 1,
  localparam int unsigned LineOffset    = Cfg.ByteOffsetLength + Cfg.BlockOffsetLength,
  localparam int unsigned PartIdWidth   = part_id_width(NumPartitions)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_we_i,
  input  logic [PartIdWidth-1:0] cfg_id_i,
  input  logic [IndexLength-1:0] cfg_start_i,
  input  logic [IndexLength:0]   cfg_size_i,
  input  logic [IndexLength-1:0] share_start_i,
  input  logic [IndexLength:0]   share_size_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  addr_t                  req_addr_i,
  input  logic [PartIdWidth-1:0] req_part_id_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IndexLength-1:0] rsp_index_o,
  output logic                   rsp_shared_o,
  output logic                   rsp_err_o,
  output part_idx_state_e        dbg_state_o
);

  // Handshake: a request transfers on a clock edge with req_valid_i && req_ready_o, a result
  // on an edge with rsp_valid_o && rsp_ready_i; a raised valid and its payload hold until then.

  localparam int unsigned AddrExtW = $bits(addr_t) + LineOffset + IndexLength;

  typedef struct packed {
    logic [IndexLength-1:0] start;
    logic [IndexLength:0]   size;
  } part_cfg_t;

  part_idx_state_e        state_q, state_d;
  part_cfg_t              table_q [NumPartitions];
  part_cfg_t              table_d [NumPartitions];
  part_cfg_t              entry;
  logic [IndexLength-1:0] line_idx;
  logic [IndexLength-1:0] op_start;
  logic [IndexLength:0]   op_size;
  logic                   op_shared, op_err, op_fast;
  logic [IndexLength-1:0] fast_rem;
  logic                   accept;
  logic                   iter_busy, iter_done;
  logic [IndexLength-1:0] iter_rem;
  logic [IndexLength-1:0] start_q, start_d;
  logic [IndexLength-1:0] index_q, index_d;
  logic                   shared_q, shared_d;
  logic                   err_q, err_d;

  // Zero-extend first so the index slice stays in range for any address width.
  assign line_idx = IndexLength'(AddrExtW'(req_addr_i) >> LineOffset);
  assign accept   = req_valid_i && (state_q == IDLE);

  always_comb begin
    for (int i = 0; i < NumPartitions; i++) begin
      table_d[i] = table_q[i];
      if (cfg_we_i && (cfg_id_i == PartIdWidth'(i))) begin
        table_d[i].start = cfg_start_i;
        table_d[i].size  = cfg_size_i;
      end
    end
  end

  // Reads come from table_q, so a write in the accept cycle is not seen by that request.
  always_comb begin
    entry = '0;
    for (int i = 0; i < NumPartitions; i++) begin
      if (req_part_id_i == PartIdWidth'(i)) entry = table_q[i];
    end
  end

  always_comb begin
    op_start  = entry.start;
    op_size   = entry.size;
    op_shared = 1'b0;
    op_err    = 1'b0;
    if (entry.size == '0) begin
      op_start  = share_start_i;
      op_size   = share_size_i;
      op_shared = 1'b1;
      op_err    = (share_size_i == '0);
    end
    op_fast  = op_err || ((op_size & (op_size - 1'b1)) == '0);
    fast_rem = op_err ? '0 : (line_idx & IndexLength'(op_size - 1'b1));
  end

  axi_llc_iter_mod #(
    .Width(IndexLength)
  ) i_iter_mod (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (accept && !op_fast),
    .dividend_i(line_idx),
    .divisor_i (op_size),
    .busy_o    (iter_busy),
    .done_o    (iter_done),
    .rem_o     (iter_rem)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      start_q  <= '0;
      index_q  <= '0;
      shared_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NumPartitions; i++) table_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      index_q  <= index_d;
      shared_q <= shared_d;
      err_q    <= err_d;
      for (int i = 0; i < NumPartitions; i++) table_q[i] <= table_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = op_fast ? DONE : CALC;
      CALC: begin
        if (iter_done)      state_d = DONE;
        else if (!iter_busy) state_d = IDLE;
      end
      DONE:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d  = start_q;
    index_d  = index_q;
    shared_d = shared_q;
    err_d    = err_q;
    if (accept) begin
      start_d  = op_start;
      shared_d = op_shared;
      err_d    = op_err;
      if (op_fast) index_d = op_start + fast_rem;
    end else if ((state_q == CALC) && iter_done) begin
      index_d = start_q + iter_rem;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE);
    rsp_valid_o  = (state_q == DONE);
    rsp_index_o  = index_q;
    rsp_shared_o = shared_q;
    rsp_err_o    = err_q;
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_axi_llc_partition_index_unit.sv
// Directed bench for the partition index unit: IndexLength=8, LineOffset=6, address 0x1240 -> line 73.
module tb_axi_llc_partition_index_unit;
  import axi_llc_pkg::*;

  localparam llc_cfg_t TbCfg = '{
    SetAssociativity: 8, NumLines: 256, NumBlocks: 8, BlockSize: 64, TagLength: 18,
    IndexLength: 8, BlockOffsetLength: 3, ByteOffsetLength: 3
  };
  localparam logic [31:0] Addr = 32'h0000_1240;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [1:0]      cfg_id;
  logic [7:0]      cfg_start;
  logic [8:0]      cfg_size;
  logic [7:0]      share_start;
  logic [8:0]      share_size;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic [1:0]      req_part_id;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_index;
  logic            rsp_shared;
  logic            rsp_err;
  part_idx_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  int lat;

  axi_llc_partition_index_unit #(
    .Cfg          (TbCfg),
    .NumPartitions(4),
    .addr_t       (logic [31:0])
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_we_i     (cfg_we),
    .cfg_id_i     (cfg_id),
    .cfg_start_i  (cfg_start),
    .cfg_size_i   (cfg_size),
    .share_start_i(share_start),
    .share_size_i (share_size),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_part_id_i(req_part_id),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_index_o  (rsp_index),
    .rsp_shared_o (rsp_shared),
    .rsp_err_o    (rsp_err),
    .dbg_state_o  (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] idx, input logic sh, input logic er);
    check({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".index"}, 32'(rsp_index), 32'(idx));
    check({tag, ".shared"}, 32'(rsp_shared), 32'(sh));
    check({tag, ".err"}, 32'(rsp_err), 32'(er));
  endtask

  // Driver tasks
  task automatic cfg_write(input logic [1:0] id, input logic [7:0] st, input logic [8:0] sz);
    @(negedge clk);
    cfg_we = 1'b1; cfg_id = id; cfg_start = st; cfg_size = sz;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_share(input logic [7:0] st, input logic [8:0] sz);
    @(negedge clk);
    share_start = st; share_size = sz;
  endtask

  task automatic send_req(input logic [1:0] id, input logic [31:0] addr);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_part_id = id;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; lat counts edges from accept (inclusive) to first valid.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid && l < 50) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_id = '0; cfg_start = '0; cfg_size = '0;
    share_start = '0; share_size = '0; req_valid = 1'b0; req_addr = '0;
    req_part_id = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset.ready", 32'(req_ready), 32'd1);
    check("reset.valid", 32'(rsp_valid), 32'd0);
    check("reset.index", 32'(rsp_index), 32'd0);
    check("reset.shared", 32'(rsp_shared), 32'd0);
    check("reset.err", 32'(rsp_err), 32'd0);

    // Slow path: 73 % 10 = 3, 16 + 3 = 19
    cfg_write(2'd1, 8'd16, 9'd10);
    send_req(2'd1, Addr);
    check("slow.busy_ready", 32'(req_ready), 32'd0);
    wait_rsp(lat);
    check("slow.latency", 32'(lat), 32'd9);
    check_rsp("slow", 8'd19, 1'b0, 1'b0);
    finish_rsp("slow");

    // Power-of-two fast path with output hold: 73 & 15 = 9, 32 + 9 = 41
    cfg_write(2'd0, 8'd32, 9'd16);
    send_req(2'd0, Addr);
    wait_rsp(lat);
    check("pow2.latency", 32'(lat), 32'd1);
    check_rsp("pow2", 8'd41, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("pow2.hold_valid", 32'(rsp_valid), 32'd1);
      check("pow2.hold_index", 32'(rsp_index), 32'd41);
      check("pow2.hold_ready", 32'(req_ready), 32'd0);
    end
    finish_rsp("pow2");

    // Shared fallback: 73 % 50 = 23, 200 + 23 = 223
    cfg_write(2'd2, 8'd0, 9'd0);
    set_share(8'd200, 9'd50);
    send_req(2'd2, Addr);
    wait_rsp(lat);
    check("share.latency", 32'(lat), 32'd9);
    check_rsp("share", 8'd223, 1'b1, 1'b0);
    finish_rsp("share");

    // Shared wrap: 73 % 20 = 13, 250 + 13 = 263 -> 7
    set_share(8'd250, 9'd20);
    send_req(2'd2, Addr);
    wait_rsp(lat);
    check_rsp("wrap", 8'd7, 1'b1, 1'b0);
    finish_rsp("wrap");

    // Error: partition and shared sizes both zero
    set_share(8'd5, 9'd0);
    send_req(2'd3, Addr);
    wait_rsp(lat);
    check("err.latency", 32'(lat), 32'd1);
    check_rsp("err", 8'd5, 1'b1, 1'b1);
    finish_rsp("err");

    // Size 256 (full range) is fast: 10 + 73 = 83
    cfg_write(2'd0, 8'd10, 9'd256);
    send_req(2'd0, Addr);
    wait_rsp(lat);
    check("size256.latency", 32'(lat), 32'd1);
    check_rsp("size256", 8'd83, 1'b0, 1'b0);
    finish_rsp("size256");

    // Size 1 is fast: remainder 0, index = start
    cfg_write(2'd2, 8'd7, 9'd1);
    send_req(2'd2, Addr);
    wait_rsp(lat);
    check("size1.latency", 32'(lat), 32'd1);
    check_rsp("size1", 8'd7, 1'b0, 1'b0);
    finish_rsp("size1");

    // Same-cycle write is not seen; mid-CALC write does not disturb the result
    @(negedge clk);
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_start = 8'd16; cfg_size = 9'd7;
    req_valid = 1'b1; req_addr = Addr; req_part_id = 2'd1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    cfg_write(2'd1, 8'd100, 9'd7);
    wait_rsp(lat);
    check_rsp("race", 8'd19, 1'b0, 1'b0);
    finish_rsp("race");

    // Next request sees size 7: 73 % 7 = 3, 16 + 3 = 19
    cfg_write(2'd1, 8'd16, 9'd7);
    send_req(2'd1, Addr);
    wait_rsp(lat);
    check("size7.latency", 32'(lat), 32'd9);
    check_rsp("size7", 8'd19, 1'b0, 1'b0);
    finish_rsp("size7");

    // Reset sampled at the end of CALC cycle 4
    send_req(2'd1, Addr);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset.valid", 32'(rsp_valid), 32'd0);
    check("midreset.ready", 32'(req_ready), 32'd1);
    check("midreset.index", 32'(rsp_index), 32'd0);
    check("midreset.err", 32'(rsp_err), 32'd0);

    // Table cleared: both partitions now fall through to an empty shared region
    set_share(8'd77, 9'd0);
    send_req(2'd1, Addr);
    wait_rsp(lat);
    check("cleared1.latency", 32'(lat), 32'd1);
    check_rsp("cleared1", 8'd77, 1'b1, 1'b1);
    finish_rsp("cleared1");
    send_req(2'd0, Addr);
    wait_rsp(lat);
    check_rsp("cleared0", 8'd77, 1'b1, 1'b1);
    finish_rsp("cleared0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
